seq_pattern_tx: RTL and testbench
=================================

Name: seq_pattern_tx

Overview:
- Moore-style serial pattern transmitter. On request, it shifts a captured WIDTH-bit pattern out MSB-first on a one-bit line.
- Repeats the pattern a programmed number of times, with an idle gap between repetitions.
- Drives the serial input of the team's sequence-detector FSMs (default pattern 101), in both bench and on-board stimulus paths.

Parameters:
- WIDTH, 3, pattern length in bits; legal range 2..16.
- GAP_CYCLES, 1, idle cycles inserted between repetitions; legal range 0..15; 0 means back-to-back.
- REP_W, 4, width of the repetition-count input.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  request; sampled only in IDLE.
- pattern  input  WIDTH  bits to send; captured when start is accepted.
- reps  input  REP_W  number of repetitions; captured when start is accepted.
- out  output  1  serial data line.
- bit_valid  output  1  high while out carries a pattern bit (or parity bit).
- busy  output  1  high from the cycle after start is accepted through the last bit or gap.
- done  output  1  one-cycle pulse when the job completes.

Behaviour:
- Reset (asynchronous, immediate): state=IDLE, out=0, bit_valid=0, busy=0, done=0; shift register, bit counter, rep counter and gap counter cleared. Reset asserted mid-transmission aborts the job, with no done pulse.
- All outputs are registered and decoded from state/registers only (Moore). Inputs never reach outputs combinationally.
- States: IDLE, SEND, PAR (compiled only with the optional feature), GAP, DONE.
- IDLE:
  - out=0, busy=0.
  - start=1 at edge k captures pattern into shreg and reps into rep_cnt.
  - reps!=0: go to SEND. First bit is on out during cycle k+1 (1-cycle latency).
  - reps==0: go directly to DONE; nothing is sent.
- SEND:
  - out=shreg[WIDTH-1], bit_valid=1, busy=1.
  - Each edge shifts shreg left and increments bit_cnt. WIDTH cycles per repetition.
  - After the last bit: go to PAR if compiled in; otherwise rep_cnt decrements.
  - If the new rep_cnt != 0: go to GAP (or reload shreg and stay in SEND when GAP_CYCLES=0).
  - If the new rep_cnt == 0: go to DONE.
- GAP:
  - out=0, bit_valid=0, busy=1 for exactly GAP_CYCLES cycles.
  - The captured pattern is reloaded into shreg, then the FSM returns to SEND.
- DONE:
  - done=1, busy=0, out=0 for exactly one cycle, then IDLE.
  - start in DONE is ignored; start is accepted again in IDLE one cycle later.
- start held high continuously: a new job starts each time IDLE is reached, i.e. one idle cycle between jobs.
- Changes to pattern or reps while busy have no effect on the current job.
- Counter widths: bit_cnt holds 0..WIDTH-1; rep_cnt is REP_W bits, and a maximum of 2^REP_W-1 repetitions is supported. No wrap-around is permitted in either counter.
- Total busy cycles for a job = reps·WIDTH + (reps-1)·GAP_CYCLES, plus reps extra cycles with the parity feature.

Optional Feature:
- Macro: SEQ_PATTERN_TX_PARITY_EN.
- Defined: after each repetition's last data bit, the FSM enters PAR for one cycle. There out = XOR of the captured pattern (even parity) and bit_valid=1. Rep decrement and the next-state decision then occur as described for SEND.
- Undefined: the PAR state and parity logic are absent, and SEND goes straight to GAP/DONE.

Test Plan:
- Default build, WIDTH=3, GAP_CYCLES=1: pattern=3'b101, reps=1, start pulse at edge 0 -> out = 1,0,1 in cycles 1-3 with bit_valid=1, busy=1 in cycles 1-3, done=1 in cycle 4, IDLE in cycle 5.
- pattern=3'b101, reps=3 -> out sequence 1,0,1,0(gap),1,0,1,0(gap),1,0,1; bit_valid low only in the two gap cycles; done pulses once in cycle 12.
- reps=0 with start -> no bit_valid assertion; done=1 in cycle 1; busy never asserted.
- Reset asserted in cycle 2 of a reps=2 job -> out, bit_valid, busy all 0 immediately (before the next edge); no done pulse; a new start after reset release sends the full pattern.
- GAP_CYCLES=0, pattern=3'b110, reps=2 -> out = 1,1,0,1,1,0 contiguous, bit_valid high 6 cycles. In the same run, start held high throughout -> second job begins after exactly one IDLE cycle following done; pattern changes during busy do not appear on out.
- SEQ_PATTERN_TX_PARITY_EN defined: pattern=3'b101, reps=1 -> out = 1,0,1,0 (parity 0), bit_valid 4 cycles. Then pattern=3'b100 -> out = 1,0,0,1.

Source files
------------

// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB-first, reps times,
// with GAP_CYCLES idle cycles between repetitions. Define SEQ_PATTERN_TX_PARITY_EN to append an even-parity bit.
module seq_pattern_tx #(
  parameter int WIDTH      = 3,
  parameter int GAP_CYCLES = 1,
  parameter int REP_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [REP_W-1:0] reps,
  output logic             out,
  output logic             bit_valid,
  output logic             busy,
  output logic             done,
  output logic [2:0]       state_dbg
);

  localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam int GAP_LAST_I = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;
  localparam logic [3:0] GAP_LAST = 4'(GAP_LAST_I);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_SEND = 3'd1,
`ifdef SEQ_PATTERN_TX_PARITY_EN
    S_PAR  = 3'd2,
`endif
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
  logic [3:0]       gap_cnt_q, gap_cnt_d;
  logic             rep_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_cnt_q <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      rep_cnt_q <= rep_cnt_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

  // start is a one-sided request: it is accepted on any edge seen in IDLE and
  // ignored in every other state, so there is no separate ready signal.
  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rep_cnt_d = rep_cnt_q;
    gap_cnt_d = gap_cnt_q;
    rep_end   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          pat_d     = pattern;
          shreg_d   = pattern;
          rep_cnt_d = reps;
          bit_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = (reps != '0) ? S_SEND : S_DONE;
        end
      end
      S_SEND: begin
        shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
        if (bit_cnt_q == BIT_LAST) begin
          bit_cnt_d = '0;
`ifdef SEQ_PATTERN_TX_PARITY_EN
          state_d   = S_PAR;
`else
          rep_end   = 1'b1;
`endif
        end else begin
          bit_cnt_d = bit_cnt_q + BW'(1);
        end
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      S_PAR: rep_end = 1'b1;
`endif
      S_GAP: begin
        if (gap_cnt_q == GAP_LAST) begin
          gap_cnt_d = '0;
          shreg_d   = pat_q;
          state_d   = S_SEND;
        end else begin
          gap_cnt_d = gap_cnt_q + 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    // End of a repetition: rep_cnt_q is never 0 here, so the decrement cannot wrap.
    if (rep_end) begin
      rep_cnt_d = rep_cnt_q - REP_W'(1);
      if (rep_cnt_q == REP_W'(1)) begin
        state_d = S_DONE;
      end else if (GAP_CYCLES == 0) begin
        shreg_d = pat_q;
        state_d = S_SEND;
      end else begin
        gap_cnt_d = '0;
        state_d   = S_GAP;
      end
    end
  end

  always_comb begin
    out       = 1'b0;
    bit_valid = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      S_SEND: begin
        out       = shreg_q[WIDTH-1];
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
`ifdef SEQ_PATTERN_TX_PARITY_EN
      S_PAR: begin
        out       = ^pat_q;
        bit_valid = 1'b1;
        busy      = 1'b1;
      end
`endif
      S_GAP:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: one instance with GAP_CYCLES=1 and one with GAP_CYCLES=0,
// checking {out, bit_valid, busy, done} cycle by cycle against hand-written sequences.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, start0;
  logic [2:0] pattern, pattern0;
  logic [3:0] reps, reps0;
  logic       out, bit_valid, busy, done;
  logic       out0, bit_valid0, busy0, done0;
  logic [2:0] state_dbg, state_dbg0;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(3), .GAP_CYCLES(1), .REP_W(4)) u_dut (
    .clk(clk), .rst(rst), .start(start), .pattern(pattern), .reps(reps),
    .out(out), .bit_valid(bit_valid), .busy(busy), .done(done), .state_dbg(state_dbg)
  );

  seq_pattern_tx #(.WIDTH(3), .GAP_CYCLES(0), .REP_W(4)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .pattern(pattern0), .reps(reps0),
    .out(out0), .bit_valid(bit_valid0), .busy(busy0), .done(done0), .state_dbg(state_dbg0)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Vectors read left to right as cycles 1..n after the start edge.
  task automatic run_job(input string tag, input logic [2:0] pat, input logic [3:0] rp,
                         input int n, input logic [15:0] e_out, input logic [15:0] e_val,
                         input logic [15:0] e_busy, input logic [15:0] e_done);
    pattern = pat;
    reps    = rp;
    start   = 1'b1;
    for (int i = 1; i <= n; i++) begin
      tick();
      if (i == 1) start = 1'b0;
      check($sformatf("%s_c%0d", tag, i), {28'd0, out, bit_valid, busy, done},
            {28'd0, e_out[n-i], e_val[n-i], e_busy[n-i], e_done[n-i]});
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; start0 = 1'b0;
    pattern = '0; reps = '0; pattern0 = '0; reps0 = '0;
    tick(); tick();
    check("reset_outs", {28'd0, out, bit_valid, busy, done}, 32'd0);
    check("reset_outs0", {28'd0, out0, bit_valid0, busy0, done0}, 32'd0);
    rst = 1'b0;
    tick();
    check("idle_state", {29'd0, state_dbg}, 32'd0);

`ifndef SEQ_PATTERN_TX_PARITY_EN
    run_job("single", 3'b101, 4'd1, 5, 16'b10100, 16'b11100, 16'b11100, 16'b00010);
    run_job("three", 3'b101, 4'd3, 13, 16'b1010101010100, 16'b1110111011100,
            16'b1111111111100, 16'b0000000000010);
    run_job("zero", 3'b111, 4'd0, 2, 16'b00, 16'b00, 16'b00, 16'b10);
    run_job("max_w", 3'b011, 4'd1, 5, 16'b01100, 16'b11100, 16'b11100, 16'b00010);
`else
    run_job("par101", 3'b101, 4'd1, 6, 16'b101000, 16'b111100, 16'b111100, 16'b000010);
    run_job("par100", 3'b100, 4'd1, 6, 16'b100100, 16'b111100, 16'b111100, 16'b000010);
    run_job("zero", 3'b111, 4'd0, 2, 16'b00, 16'b00, 16'b00, 16'b10);
`endif

    // Reset in the second cycle of a two-repetition job.
    pattern = 3'b101; reps = 4'd2; start = 1'b1;
    tick();
    start = 1'b0;
    check("rst_job_c1", {28'd0, out, bit_valid, busy, done}, {28'd0, 4'b1110});
    tick();
    check("rst_job_c2", {28'd0, out, bit_valid, busy, done}, {28'd0, 4'b0110});
    rst = 1'b1;
    #1;
    check("rst_async", {28'd0, out, bit_valid, busy, done}, 32'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("rst_quiet_%0d", i), {28'd0, out, bit_valid, busy, done}, 32'd0);
    end
`ifndef SEQ_PATTERN_TX_PARITY_EN
    run_job("after_rst", 3'b011, 4'd1, 5, 16'b01100, 16'b11100, 16'b11100, 16'b00010);
`else
    run_job("after_rst", 3'b011, 4'd1, 6, 16'b011000, 16'b111100, 16'b111100, 16'b000010);
`endif

`ifndef SEQ_PATTERN_TX_PARITY_EN
    // Back-to-back build, start held high; inputs change during the first job.
    begin
      logic [11:0] e_out, e_val, e_busy, e_done;
      e_out  = 12'b110110000010;
      e_val  = 12'b111111001110;
      e_busy = 12'b111111001110;
      e_done = 12'b000000100001;
      pattern0 = 3'b110; reps0 = 4'd2; start0 = 1'b1;
      for (int i = 1; i <= 12; i++) begin
        tick();
        if (i == 1) begin
          pattern0 = 3'b001;
          reps0    = 4'd1;
        end
        check($sformatf("gap0_c%0d", i), {28'd0, out0, bit_valid0, busy0, done0},
              {28'd0, e_out[12-i], e_val[12-i], e_busy[12-i], e_done[12-i]});
      end
      start0 = 1'b0;
      tick();
      check("gap0_idle", {29'd0, state_dbg0}, 32'd0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
